mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_mem_responder.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Byte-serial memory responder: turns word/half/byte fetch, load and store
// requests into one-byte-per-cycle RAM accesses.
module mem_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_valid,
    input  logic        ls_is_store,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic        flush,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [31:0] base, base_n;
    logic [2:0]  f3, f3_n;
    logic [31:0] wdat, wdat_n;
    logic [31:0] acc, acc_n;
    logic        paused, paused_n;
    logic [31:0] a_q, a_n;
    logic [7:0]  dout_q, dout_n;
    logic        wr_q, wr_n;
    logic        if_done_n, ls_done_n;
    logic [31:0] if_data_n, ls_rdata_n;
    logic [2:0]  n;
    logic [2:0]  idx;
    logic        ls_block;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f);
        case (f)
            3'd0:    extend = {{24{w[7]}}, w[7:0]};
            3'd1:    extend = {{16{w[15]}}, w[15:0]};
            3'd4:    extend = {24'd0, w[7:0]};
            3'd5:    extend = {16'd0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    assign ls_block = ls_is_store && (ls_addr[17:16] == 2'b11) && io_buffer_full;
    assign n = (state == IF_RD || f3 == 3'd2) ? 3'd4 : (f3[0] ? 3'd2 : 3'd1);
    assign mem_a = a_q;
    assign mem_dout = dout_q;
    assign mem_wr = wr_q & rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            base     <= '0;
            f3       <= '0;
            wdat     <= '0;
            acc      <= '0;
            paused   <= 1'b0;
            a_q      <= '0;
            dout_q   <= '0;
            wr_q     <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            base     <= base_n;
            f3       <= f3_n;
            wdat     <= wdat_n;
            acc      <= acc_n;
            paused   <= paused_n;
            a_q      <= a_n;
            dout_q   <= dout_n;
            wr_q     <= wr_n;
            if_done  <= if_done_n;
            ls_done  <= ls_done_n;
            if_data  <= if_data_n;
            ls_rdata <= ls_rdata_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        base_n     = base;
        f3_n       = f3;
        wdat_n     = wdat;
        acc_n      = acc;
        paused_n   = paused;
        a_n        = a_q;
        dout_n     = dout_q;
        wr_n       = wr_q;
        if_done_n  = 1'b0;
        ls_done_n  = 1'b0;
        if_data_n  = if_data;
        ls_rdata_n = ls_rdata;
        idx        = cnt - 3'd2;
        if (!rdy) begin
            // Everything holds; a paused read must refetch from byte 0.
            if_done_n = if_done;
            ls_done_n = ls_done;
            paused_n  = paused | (state == IF_RD) | (state == LS_RD);
        end else begin
            unique case (state)
                IDLE: begin
                    a_n    = '0;
                    dout_n = '0;
                    wr_n   = 1'b0;
                    if (!flush && !if_done && !ls_done) begin
                        if (ls_valid && !ls_block) begin
                            base_n = ls_addr;
                            f3_n   = ls_funct3;
                            wdat_n = ls_wdata;
                            acc_n  = '0;
                            cnt_n  = 3'd1;
                            a_n    = ls_addr;
                            if (ls_is_store) begin
                                state_n = LS_WR;
                                dout_n  = ls_wdata[7:0];
                                wr_n    = 1'b1;
                            end else begin
                                state_n = LS_RD;
                            end
                        end else if (if_valid) begin
                            base_n  = if_addr;
                            acc_n   = '0;
                            cnt_n   = 3'd1;
                            a_n     = if_addr;
                            state_n = IF_RD;
                        end
                    end
                end
                IF_RD, LS_RD: begin
                    if (flush) begin
                        state_n  = IDLE;
                        a_n      = '0;
                        paused_n = 1'b0;
                    end else if (paused) begin
                        a_n      = base;
                        cnt_n    = 3'd1;
                        paused_n = 1'b0;
                    end else begin
                        a_n = (cnt < n) ? base + {29'd0, cnt} : '0;
                        if (cnt >= 3'd2)
                            acc_n[{idx[1:0], 3'b000} +: 8] = mem_din;
                        cnt_n = cnt + 3'd1;
                        if (cnt == n + 3'd1) begin
                            state_n = IDLE;
                            if (state == IF_RD) begin
                                if_done_n = 1'b1;
                                if_data_n = acc_n;
                            end else begin
                                ls_done_n  = 1'b1;
                                ls_rdata_n = extend(acc_n, f3);
                            end
                        end
                    end
                end
                LS_WR: begin
                    if (cnt == n) begin
                        state_n   = IDLE;
                        a_n       = '0;
                        dout_n    = '0;
                        wr_n      = 1'b0;
                        ls_done_n = 1'b1;
                    end else begin
                        a_n    = base + {29'd0, cnt};
                        dout_n = wdat[{cnt[1:0], 3'b000} +: 8];
                        wr_n   = 1'b1;
                        cnt_n  = cnt + 3'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: byte-addressed RAM model with one-cycle read
// latency and a transaction-level reference for fetch/load/store results.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_valid = 1'b0;
    logic        ls_is_store = 1'b0;
    logic [2:0]  ls_funct3 = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        flush = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int vec = 0;
    int errs = 0;

    logic [7:0]  ram [int unsigned];
    logic [39:0] wlog [$];

    mem_responder dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid(if_valid), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data),
        .ls_valid(ls_valid), .ls_is_store(ls_is_store),
        .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata),
        .flush(flush), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3c;
    endfunction

    always @(posedge clk) begin
        mem_din <= rd(mem_a);
        if (mem_wr === 1'b1) begin
            ram[mem_a] = mem_dout;
            wlog.push_back({mem_a, mem_dout});
        end
    end

    function automatic int nbytes(input bit is_if, input logic [2:0] f);
        if (is_if || f == 3'd2) return 4;
        if (f == 3'd1 || f == 3'd5) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] ref_load(input bit is_if, input logic [2:0] f,
                                             input logic [31:0] a);
        int nb;
        logic [31:0] w;
        nb = nbytes(is_if, f);
        w = 0;
        for (int k = 0; k < nb; k++)
            w = w + ({24'd0, rd(a + 32'(k))} << (8 * k));
        if (is_if) return w;
        case (f)
            3'd0: return w[7] ? (w | 32'hFFFFFF00) : w;
            3'd1: return w[15] ? (w | 32'hFFFF0000) : w;
            default: return w;
        endcase
    endfunction

    function automatic logic [7:0] wbyte(input logic [31:0] w, input int k);
        logic [31:0] s;
        s = w >> (8 * k);
        return s[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input bit is_if, input logic [2:0] f, input logic [31:0] a);
        int nb;
        logic [31:0] exp, got, held;
        logic dn;
        nb = nbytes(is_if, f);
        exp = ref_load(is_if, f, a);
        if (is_if) begin
            if_valid = 1'b1; if_addr = a;
        end else begin
            ls_valid = 1'b1; ls_is_store = 1'b0; ls_funct3 = f; ls_addr = a;
        end
        for (int e = 0; e <= nb + 1; e++) begin
            tick();
            if (e == 0) begin if_valid = 1'b0; ls_valid = 1'b0; end
            vec++;
            if (mem_a !== ((e < nb) ? a + 32'(e) : 32'd0)) begin
                errs++;
                $display("FAIL rd_addr e=%0d got %h want %h", e, mem_a,
                         (e < nb) ? a + 32'(e) : 32'd0);
            end
            vec++;
            if (mem_wr !== 1'b0) begin
                errs++; $display("FAIL rd_wr e=%0d got %b want 0", e, mem_wr);
            end
            dn = is_if ? if_done : ls_done;
            vec++;
            if (dn !== (e == nb + 1)) begin
                errs++; $display("FAIL rd_done e=%0d got %b want %b", e, dn, e == nb + 1);
            end
            if (e == nb + 1) begin
                got = is_if ? if_data : ls_rdata;
                vec++;
                if (got !== exp) begin
                    errs++;
                    $display("FAIL rd_data f3=%0d a=%h got %h want %h", f, a, got, exp);
                end
            end
        end
        tick();
        dn = is_if ? if_done : ls_done;
        held = is_if ? if_data : ls_rdata;
        vec++;
        if (dn !== 1'b0 || held !== exp) begin
            errs++; $display("FAIL rd_hold done %b data %h want 0 %h", dn, held, exp);
        end
    endtask

    task automatic do_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
        int nb;
        nb = nbytes(1'b0, f);
        wlog.delete();
        ls_valid = 1'b1; ls_is_store = 1'b1; ls_funct3 = f; ls_addr = a; ls_wdata = wd;
        for (int e = 0; e <= nb; e++) begin
            tick();
            if (e == 0) ls_valid = 1'b0;
            if (e < nb) begin
                vec++;
                if (mem_a !== a + 32'(e) || mem_wr !== 1'b1 || mem_dout !== wbyte(wd, e)
                    || ls_done !== 1'b0) begin
                    errs++;
                    $display("FAIL st_byte e=%0d got a=%h wr=%b d=%h dn=%b want a=%h wr=1 d=%h dn=0",
                             e, mem_a, mem_wr, mem_dout, ls_done, a + 32'(e), wbyte(wd, e));
                end
            end else begin
                vec++;
                if (mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'd0 || ls_done !== 1'b1) begin
                    errs++;
                    $display("FAIL st_done got a=%h wr=%b d=%h dn=%b want 0 0 0 1",
                             mem_a, mem_wr, mem_dout, ls_done);
                end
            end
        end
        tick();
        vec++;
        if (wlog.size() != nb) begin
            errs++; $display("FAIL st_count got %0d want %0d", wlog.size(), nb);
        end
        for (int k = 0; k < nb; k++) begin
            vec++;
            if (rd(a + 32'(k)) !== wbyte(wd, k)) begin
                errs++;
                $display("FAIL st_ram a=%h got %h want %h", a + 32'(k), rd(a + 32'(k)), wbyte(wd, k));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vec++;
        if ({if_done, ls_done, if_data, ls_rdata, mem_a, mem_dout, mem_wr} !== '0) begin
            errs++;
            $display("FAIL reset got ifd=%b lsd=%b ifdat=%h lsdat=%h a=%h d=%h wr=%b want all 0",
                     if_done, ls_done, if_data, ls_rdata, mem_a, mem_dout, mem_wr);
        end
        rst = 1'b0;
        tick();
        if_valid = 1'b1; if_addr = 32'h700;
        tick(); if_valid = 1'b0;
        tick(); tick();
        rst = 1'b1; rdy = 1'b0; flush = 1'b1;
        tick();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        vec++;
        if ({if_done, mem_a, mem_dout, mem_wr} !== '0) begin
            errs++; $display("FAIL reset_mid got a=%h done=%b want 0", mem_a, if_done);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            vec++;
            if (if_done !== 1'b0 || mem_a !== 32'd0) begin
                errs++; $display("FAIL reset_discard got done=%b a=%h want 0", if_done, mem_a);
            end
        end
    endtask

    task automatic test_if_read();
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05;
        ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        do_read(1'b1, 3'd0, 32'h100);
        vec++;
        if (if_data !== 32'h00000513) begin
            errs++; $display("FAIL if_word got %h want 00000513", if_data);
        end
    endtask

    task automatic test_priority();
        logic [31:0] exp_if;
        ram[32'h20] = 8'h80;
        exp_if = ref_load(1'b1, 3'd0, 32'h100);
        ls_valid = 1'b1; ls_is_store = 1'b0; ls_funct3 = 3'd0; ls_addr = 32'h20;
        if_valid = 1'b1; if_addr = 32'h100;
        for (int e = 0; e <= 9; e++) begin
            tick();
            if (e == 0) ls_valid = 1'b0;
            if (e == 0) begin
                vec++;
                if (mem_a !== 32'h20) begin
                    errs++; $display("FAIL prio_ls_first got %h want 00000020", mem_a);
                end
            end
            if (e == 2) begin
                vec++;
                if (ls_done !== 1'b1 || ls_rdata !== 32'hFFFFFF80) begin
                    errs++; $display("FAIL prio_lb got dn=%b %h want 1 ffffff80", ls_done, ls_rdata);
                end
            end
            if (e == 3) begin
                vec++;
                if (mem_a !== 32'd0 || ls_done !== 1'b0) begin
                    errs++; $display("FAIL prio_gap got a=%h dn=%b want 0 0", mem_a, ls_done);
                end
            end
            if (e == 4) begin
                if_valid = 1'b0;
                vec++;
                if (mem_a !== 32'h100) begin
                    errs++; $display("FAIL prio_if_start got %h want 00000100", mem_a);
                end
            end
            if (e == 9) begin
                vec++;
                if (if_done !== 1'b1 || if_data !== exp_if) begin
                    errs++; $display("FAIL prio_if_done got %b %h want 1 %h", if_done, if_data, exp_if);
                end
            end
        end
        tick();
    endtask

    task automatic test_store_sh();
        do_store(3'd1, 32'h1FFFF, 32'h0000BEEF);
        vec++;
        if (wlog.size() != 2 || wlog[0] !== {32'h1FFFF, 8'hEF} || wlog[1] !== {32'h20000, 8'hBE}) begin
            errs++; $display("FAIL sh_log got %0d writes want EF@1ffff BE@20000", wlog.size());
        end
    endtask

    task automatic test_io_stall();
        ls_valid = 1'b1; ls_is_store = 1'b1; ls_funct3 = 3'd0;
        ls_addr = 32'h30000; ls_wdata = 32'h123456A5; io_buffer_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++;
            if (mem_wr !== 1'b0 || mem_a !== 32'd0) begin
                errs++; $display("FAIL io_block got wr=%b a=%h want 0 0", mem_wr, mem_a);
            end
        end
        io_buffer_full = 1'b0;
        tick();
        ls_valid = 1'b0;
        vec++;
        if (mem_wr !== 1'b1 || mem_dout !== 8'hA5 || mem_a !== 32'h30000) begin
            errs++; $display("FAIL io_write got wr=%b d=%h a=%h want 1 a5 30000", mem_wr, mem_dout, mem_a);
        end
        tick();
        vec++;
        if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin
            errs++; $display("FAIL io_done got dn=%b wr=%b want 1 0", ls_done, mem_wr);
        end
        tick();
        ls_valid = 1'b1; ls_is_store = 1'b1; ls_addr = 32'h3FF00; io_buffer_full = 1'b1;
        if_valid = 1'b1; if_addr = 32'h200;
        tick();
        ls_valid = 1'b0; if_valid = 1'b0; io_buffer_full = 1'b0;
        vec++;
        if (mem_a !== 32'h200 || mem_wr !== 1'b0) begin
            errs++; $display("FAIL io_if_instead got a=%h wr=%b want 200 0", mem_a, mem_wr);
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_flush();
        if_valid = 1'b1; if_addr = 32'h300;
        tick(); if_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vec++;
        if (mem_a !== 32'd0 || if_done !== 1'b0 || mem_wr !== 1'b0) begin
            errs++; $display("FAIL flush_idle got a=%h dn=%b wr=%b want 0 0 0", mem_a, if_done, mem_wr);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vec++;
            if (if_done !== 1'b0 || mem_a !== 32'd0 || mem_wr !== 1'b0) begin
                errs++; $display("FAIL flush_quiet got dn=%b a=%h wr=%b want 0 0 0", if_done, mem_a, mem_wr);
            end
        end
        flush = 1'b1; ls_valid = 1'b1; ls_is_store = 1'b0; ls_addr = 32'h44;
        tick();
        flush = 1'b0; ls_valid = 1'b0;
        vec++;
        if (mem_a !== 32'd0) begin
            errs++; $display("FAIL flush_noaccept got a=%h want 0", mem_a);
        end
        tick();
    endtask

    task automatic test_flush_store();
        int seen;
        seen = 0;
        wlog.delete();
        ls_valid = 1'b1; ls_is_store = 1'b1; ls_funct3 = 3'd2; ls_addr = 32'h500; ls_wdata = 32'h89ABCDEF;
        tick(); ls_valid = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ls_done === 1'b1) seen++;
        end
        flush = 1'b0;
        vec++;
        if (seen != 1 || wlog.size() != 4 || rd(32'h503) !== 8'h89 || rd(32'h500) !== 8'hEF) begin
            errs++; $display("FAIL flush_store got done=%0d writes=%0d want 1 4", seen, wlog.size());
        end
    endtask

    task automatic test_pause();
        int seen;
        ram[32'h40] = 8'h78; ram[32'h41] = 8'h56; ram[32'h42] = 8'h34; ram[32'h43] = 8'h12;
        ls_valid = 1'b1; ls_is_store = 1'b0; ls_funct3 = 3'd2; ls_addr = 32'h40;
        for (int e = 0; e <= 9; e++) begin
            tick();
            if (e == 0) ls_valid = 1'b0;
            if (e == 1) rdy = 1'b0;
            if (e == 3) rdy = 1'b1;
            vec++;
            if (mem_wr !== 1'b0) begin
                errs++; $display("FAIL pause_wr e=%0d got %b want 0", e, mem_wr);
            end
            if (e == 2 || e == 3) begin
                vec++;
                if (mem_a !== 32'h41) begin
                    errs++; $display("FAIL pause_hold e=%0d got %h want 00000041", e, mem_a);
                end
            end
            if (e == 4) begin
                vec++;
                if (mem_a !== 32'h40) begin
                    errs++; $display("FAIL pause_restart got %h want 00000040", mem_a);
                end
            end
        end
        vec++;
        if (ls_done !== 1'b1 || ls_rdata !== 32'h12345678) begin
            errs++; $display("FAIL pause_lw got dn=%b %h want 1 12345678", ls_done, ls_rdata);
        end
        tick();
        wlog.delete();
        seen = 0;
        ls_valid = 1'b1; ls_is_store = 1'b1; ls_funct3 = 3'd2; ls_addr = 32'h600; ls_wdata = 32'hCAFEF00D;
        tick(); ls_valid = 1'b0;
        rdy = 1'b0;
        #1;
        vec++;
        if (mem_wr !== 1'b0) begin
            errs++; $display("FAIL pause_st_wr got %b want 0", mem_wr);
        end
        tick();
        vec++;
        if (mem_a !== 32'h600 || mem_dout !== 8'h0D || mem_wr !== 1'b0) begin
            errs++; $display("FAIL pause_st_hold got a=%h d=%h wr=%b want 600 0d 0", mem_a, mem_dout, mem_wr);
        end
        rdy = 1'b1;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            tick();
            if (ls_done === 1'b1) seen = 1;
        end
        vec++;
        if (seen != 1 || wlog.size() != 4 || wlog[0] !== {32'h600, 8'h0D} || wlog[3] !== {32'h603, 8'hCA}) begin
            errs++; $display("FAIL pause_sw got done=%0d writes=%0d want 1 4", seen, wlog.size());
        end
        tick();
    endtask

    task automatic test_random();
        logic [2:0] lf [5];
        int kind;
        logic [31:0] a;
        lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(2);
            a = $urandom;
            if ($urandom_range(3) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(3));
            if (kind == 0) do_read(1'b1, 3'd0, a);
            else if (kind == 1) do_read(1'b0, lf[$urandom_range(4)], a);
            else do_store(3'($urandom_range(2)), a, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_priority();
        test_store_sh();
        test_io_stall();
        test_flush();
        test_flush_store();
        test_pause();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
